// File: rtl/decode_stage.sv
// Registered MIPS decode stage: combinational decode into a main/skid pair with valid/ready on both sides.
// Optional load-use interlock (adds hazard_stall port) when DECODE_HAZARD_EN is defined.
module decode_stage #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned ALU_W = 12,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [REG_W-1:0] out_rs,
  output logic [REG_W-1:0] out_rt,
  output logic [REG_W-1:0] out_rd,
  output logic             out_write_reg,
  output logic [ALU_W-1:0] out_alu_control,
  output logic [31:0]      out_imm,
  output logic             out_use_imm,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_illegal,
`ifdef DECODE_HAZARD_EN
  output logic             hazard_stall,
`endif
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [31:0]      pc;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             write_reg;
    logic [ALU_W-1:0] alu;
    logic [31:0]      imm;
    logic             use_imm;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             illegal;
  } bundle_t;

  bundle_t          dec;
  bundle_t          main_q, main_d, skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire;

  logic [5:0] op, fn;
  logic [4:0] dest;
  logic       is_r, r_ok, i_ok;
  logic       is_addi, is_addiu, is_andi, is_ori, is_lui, is_lw, is_sw, is_beq;

  always_comb begin
    op       = in_instr[31:26];
    fn       = in_instr[5:0];
    is_r     = (op == 6'b000000);
    r_ok     = is_r && (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b100100 ||
                        fn == 6'b100101 || fn == 6'b101010);
    is_addi  = (op == 6'b001000);
    is_addiu = (op == 6'b001001);
    is_andi  = (op == 6'b001100);
    is_ori   = (op == 6'b001101);
    is_lui   = (op == 6'b001111);
    is_lw    = (op == 6'b100011);
    is_sw    = (op == 6'b101011);
    is_beq   = (op == 6'b000100);
    i_ok     = is_addi | is_addiu | is_andi | is_ori | is_lui | is_lw | is_sw | is_beq;
    dest     = is_r ? in_instr[15:11] : in_instr[20:16];

    dec           = '0;
    dec.pc        = in_pc;
    dec.rs        = REG_W'(in_instr[25:21]);
    dec.rt        = REG_W'(in_instr[20:16]);
    dec.rd        = REG_W'(in_instr[15:11]);
    dec.illegal   = !(r_ok | i_ok);
    dec.use_imm   = i_ok & !is_beq;
    dec.mem_read  = is_lw;
    dec.mem_write = is_sw;
    dec.branch    = is_beq;
    dec.write_reg = (r_ok | i_ok) & !is_sw & !is_beq & (dest != 5'd0);
    if (r_ok)      dec.alu = ALU_W'({6'b000000, fn});
    else if (i_ok) dec.alu = ALU_W'({op, 6'b000000});
    else           dec.alu = '1;
    if (is_andi | is_ori) dec.imm = {16'h0000, in_instr[15:0]};
    else if (is_lui)      dec.imm = {in_instr[15:0], 16'h0000};
    else                  dec.imm = {{16{in_instr[15]}}, in_instr[15:0]};
  end

`ifdef DECODE_HAZARD_EN
  logic reads_rt, hazard;
  always_comb begin
    reads_rt = is_r | is_sw | is_beq;
    hazard   = in_valid && main_valid_q && main_q.mem_read && (main_q.rt != '0) &&
               ((dec.rs == main_q.rt) || (reads_rt && dec.rt == main_q.rt));
  end
  assign hazard_stall = hazard;
  assign in_ready     = in_ready_q & !hazard;
`else
  assign in_ready = in_ready_q;
`endif

  assign in_fire = in_valid & in_ready & !flush;

  // Drain first so a freed main slot takes the skid entry (or the new word) in order.
  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    cnt_d        = cnt_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (main_valid_q && out_ready) begin
        main_valid_d = skid_valid_q;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
      if (in_fire) begin
        if (!main_valid_d) begin
          main_valid_d = 1'b1;
          main_d       = dec;
        end else begin
          skid_valid_d = 1'b1;
          skid_d       = dec;
        end
        if (dec.illegal && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid       = main_valid_q;
  assign out_pc          = main_q.pc;
  assign out_rs          = main_q.rs;
  assign out_rt          = main_q.rt;
  assign out_rd          = main_q.rd;
  assign out_write_reg   = main_q.write_reg;
  assign out_alu_control = main_q.alu;
  assign out_imm         = main_q.imm;
  assign out_use_imm     = main_q.use_imm;
  assign out_mem_read    = main_q.mem_read;
  assign out_mem_write   = main_q.mem_write;
  assign out_branch      = main_q.branch;
  assign out_illegal     = main_q.illegal;
  assign illegal_count   = cnt_q;

endmodule
